// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the decode-side control: opcodes, subcodes,
// fetch PC-source select codes and the decode sequencer state type.
package cpu_isa_pkg;

    localparam logic [3:0] OP_JCC      = 4'h9;
    localparam logic [3:0] OP_LOOP     = 4'hA;
    localparam logic [3:0] OP_STACK    = 4'hB;
    localparam logic [3:0] OP_TWO_WORD = 4'hC;

    // Jcc condition subcodes, instr[3:2]
    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_N  = 2'b01;
    localparam logic [1:0] CC_C  = 2'b10;
    localparam logic [1:0] CC_AL = 2'b11;

    // Stack-group subcodes, instr[3:2]; 2'b11 is an unassigned NOP
    localparam logic [1:0] SUB_CALL = 2'b00;
    localparam logic [1:0] SUB_RET  = 2'b01;
    localparam logic [1:0] SUB_RTI  = 2'b10;

    localparam logic [2:0] SEL_PC1 = 3'b000;
    localparam logic [2:0] SEL_REG = 3'b001;
    localparam logic [2:0] SEL_VEC = 3'b010;
    localparam logic [2:0] SEL_STK = 3'b011;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_INT_PUSH = 2'd2,
        S_INT_VEC  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/decode_sequencer_branch_cond.sv
// Jcc condition evaluation: selects the flag named by the subcode, or
// always-taken for JMP.
module branch_cond
    import cpu_isa_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_c,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_Z:    taken = flag_z;
            CC_N:    taken = flag_n;
            CC_C:    taken = flag_c;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_sequencer.sv
// Decode-side sequencer driving fetch steering and pipeline control.
// Interrupt entry is built only when DECODE_SEQ_INTR_EN is defined.
module decode_sequencer
    import cpu_isa_pkg::*;
#(
    parameter logic [2:0] VEC_SEL = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instrD,
    input  logic [7:0] pcD,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_c,
    input  logic       or_out,
    input  logic       hz_stall,
    input  logic       intr,
    output logic [2:0] mux1_sel,
    output logic       loop_en,
    output logic       IR_en,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       push_pc,
    output logic       pop_pc,
    output logic [7:0] ret_pc,
    output logic       intr_ack
);

    seq_state_t state, state_nxt;
    logic [3:0] opcode;
    logic [1:0] sub;
    logic       jcc_taken;
    logic       int_ok;

    assign opcode = instrD[7:4];
    assign sub    = instrD[3:2];

    branch_cond u_branch_cond (
        .cond   (sub),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .taken  (jcc_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= state_nxt;
    end

`ifdef DECODE_SEQ_INTR_EN
    logic pend, in_isr, rti_pend;
    logic rti_set, ret_done, vec_done;

    assign rti_set  = (state == S_RUN) && !hz_stall &&
                      (opcode == OP_STACK) && (sub == SUB_RTI);
    assign ret_done = (state == S_RET_WAIT);
    assign vec_done = (state == S_INT_VEC);
    assign int_ok   = pend && !in_isr;

    // A level intr still high during the vector cycle must not re-arm pend.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= 1'b0;
            in_isr   <= 1'b0;
            rti_pend <= 1'b0;
        end else begin
            if (vec_done) begin
                pend   <= 1'b0;
                in_isr <= 1'b1;
            end else if (intr && !in_isr) begin
                pend <= 1'b1;
            end
            if (ret_done) begin
                if (rti_pend) in_isr <= 1'b0;
                rti_pend <= 1'b0;
            end else if (rti_set) begin
                rti_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_intr;
    assign unused_intr = &{1'b0, intr, VEC_SEL};
    assign int_ok      = 1'b0;
`endif

    logic unused_instr;
    assign unused_instr = &{1'b0, instrD[1:0]};

    always_comb begin
        state_nxt = state;
        mux1_sel  = SEL_PC1;
        loop_en   = 1'b0;
        IR_en     = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        push_pc   = 1'b0;
        pop_pc    = 1'b0;
        ret_pc    = pcD + 8'd1;
        intr_ack  = 1'b0;
        // Reset holds every output at its default so no push/pop escapes.
        if (!reset) begin
            case (state)
                S_RUN: begin
                    if (hz_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                    end else if (opcode == OP_TWO_WORD) begin
                        IR_en  = 1'b1;
                        FlushD = 1'b1;
                    end else if (opcode == OP_JCC) begin
                        if (jcc_taken) begin
                            mux1_sel = SEL_REG;
                            FlushD   = 1'b1;
                        end
                    end else if (opcode == OP_LOOP) begin
                        loop_en  = 1'b1;
                        mux1_sel = SEL_REG;
                        FlushD   = or_out;
                    end else if (opcode == OP_STACK) begin
                        if (sub == SUB_CALL) begin
                            push_pc  = 1'b1;
                            mux1_sel = SEL_REG;
                            FlushD   = 1'b1;
                        end else if (sub == SUB_RET || sub == SUB_RTI) begin
                            pop_pc    = 1'b1;
                            StallF    = 1'b1;
                            FlushD    = 1'b1;
                            state_nxt = S_RET_WAIT;
                        end
                    end else if (int_ok) begin
                        state_nxt = S_INT_PUSH;
                    end
                end
                S_RET_WAIT: begin
                    mux1_sel  = SEL_STK;
                    FlushD    = 1'b1;
                    state_nxt = S_RUN;
                end
`ifdef DECODE_SEQ_INTR_EN
                // The squashed decode instruction is re-executed after the ISR.
                S_INT_PUSH: begin
                    push_pc   = 1'b1;
                    ret_pc    = pcD;
                    StallF    = 1'b1;
                    FlushD    = 1'b1;
                    state_nxt = S_INT_VEC;
                end
                S_INT_VEC: begin
                    mux1_sel  = VEC_SEL;
                    FlushD    = 1'b1;
                    intr_ack  = 1'b1;
                    state_nxt = S_RUN;
                end
`endif
                default: state_nxt = S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Randomized self-checking bench for decode_sequencer against a
// schedule-queue reference model of the decode sequencing rules.
module tb_decode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instrD, pcD;
    logic       flag_z, flag_n, flag_c, or_out, hz_stall, intr;
    logic [2:0] mux1_sel;
    logic       loop_en, IR_en, StallF, StallD, FlushD, push_pc, pop_pc, intr_ack;
    logic [7:0] ret_pc;

    always #5 clk = ~clk;

    decode_sequencer dut (
        .clk(clk), .reset(reset), .instrD(instrD), .pcD(pcD),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .or_out(or_out), .hz_stall(hz_stall), .intr(intr),
        .mux1_sel(mux1_sel), .loop_en(loop_en), .IR_en(IR_en),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .push_pc(push_pc), .pop_pc(pop_pc), .ret_pc(ret_pc),
        .intr_ack(intr_ack)
    );

`ifdef DECODE_SEQ_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif
    localparam logic [2:0] VEC = 3'b010;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Work the model must do on upcoming cycles, regardless of decode input.
    typedef enum int {K_RETWAIT, K_PUSH, K_VEC} kind_t;
    kind_t sched[$];
    bit m_pend, m_isr, m_rti;
    logic [18:0] last_obs;

    task automatic model(output logic [18:0] e);
        logic [2:0] mux;
        logic le, ir, sf, sd, fd, pu, po, ak, tk;
        logic [7:0] rp;
        bit old_isr, vec;
        kind_t k;
        mux = 3'd0; le = 0; ir = 0; sf = 0; sd = 0; fd = 0; pu = 0; po = 0; ak = 0;
        rp = pcD + 8'd1;
        old_isr = m_isr;
        vec = 0;
        if (reset) begin
            sched.delete();
            m_pend = 0; m_isr = 0; m_rti = 0;
        end else begin
            if (sched.size() > 0) begin
                k = sched.pop_front();
                if (k == K_RETWAIT) begin
                    mux = 3'd3; fd = 1;
                    if (m_rti) m_isr = 0;
                    m_rti = 0;
                end else if (k == K_PUSH) begin
                    pu = 1; rp = pcD; sf = 1; fd = 1;
                end else begin
                    mux = VEC; fd = 1; ak = 1;
                    m_isr = 1; m_pend = 0; vec = 1;
                end
            end else if (hz_stall) begin
                sf = 1; sd = 1;
            end else begin
                case (instrD[7:4])
                    4'hC: begin ir = 1; fd = 1; end
                    4'h9: begin
                        case (instrD[3:2])
                            2'd0: tk = flag_z;
                            2'd1: tk = flag_n;
                            2'd2: tk = flag_c;
                            default: tk = 1'b1;
                        endcase
                        if (tk) begin mux = 3'd1; fd = 1; end
                    end
                    4'hA: begin le = 1; mux = 3'd1; fd = or_out; end
                    4'hB: begin
                        if (instrD[3:2] == 2'd0) begin
                            pu = 1; mux = 3'd1; fd = 1;
                        end else if (instrD[3:2] != 2'd3) begin
                            po = 1; sf = 1; fd = 1;
                            sched.push_back(K_RETWAIT);
                            if (INTR_EN && instrD[3:2] == 2'd2) m_rti = 1;
                        end
                    end
                    default: begin
                        if (INTR_EN && m_pend && !m_isr) begin
                            sched.push_back(K_PUSH);
                            sched.push_back(K_VEC);
                        end
                    end
                endcase
            end
            if (INTR_EN && intr && !old_isr && !vec) m_pend = 1;
        end
        e = {mux, le, ir, sf, sd, fd, pu, po, ak, rp};
    endtask

    task automatic cycle(input string tag);
        logic [18:0] e;
        @(negedge clk);
        model(e);
        last_obs = {mux1_sel, loop_en, IR_en, StallF, StallD, FlushD,
                    push_pc, pop_pc, intr_ack, ret_pc};
        check_eq(tag, 32'(last_obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // Control bits only (everything except ret_pc).
    function automatic logic [31:0] ctl();
        return 32'(last_obs[18:8]);
    endfunction

    logic [3:0] op_tbl [10];

    initial begin
        op_tbl = '{4'h0, 4'h1, 4'h3, 4'h9, 4'h9, 4'hA, 4'hB, 4'hB, 4'hC, 4'h5};
        reset = 1; instrD = 8'h00; pcD = 8'h00;
        flag_z = 0; flag_n = 0; flag_c = 0; or_out = 0; hz_stall = 0; intr = 0;
        cycle("reset0");
        cycle("reset1");
        reset = 0;
        cycle("nop");
        check_eq("nop_ctl", ctl(), 32'h0);
        check_eq("nop_ret_pc", 32'(last_obs[7:0]), 32'h01);

        instrD = 8'h90; flag_z = 1;
        cycle("jz_taken");
        check_eq("jz_taken_mux", 32'(last_obs[18:16]), 32'd1);
        check_eq("jz_taken_flush", 32'(last_obs[11]), 32'd1);
        flag_z = 0;
        cycle("jz_not");
        check_eq("jz_not_ctl", ctl(), 32'h0);

        instrD = 8'hA0; or_out = 1;
        cycle("loop1");
        check_eq("loop1_en_flush", 32'({last_obs[15], last_obs[11]}), 32'b11);
        or_out = 0;
        cycle("loop0");
        check_eq("loop0_en_flush", 32'({last_obs[15], last_obs[11]}), 32'b10);

        instrD = 8'hB4; pcD = 8'h20;
        cycle("ret_c0");
        check_eq("ret_c0_pop_sf_fd", 32'({last_obs[9], last_obs[13], last_obs[11]}), 32'b111);
        cycle("ret_c1");
        check_eq("ret_c1_mux", 32'(last_obs[18:16]), 32'd3);
        check_eq("ret_c1_flush", 32'(last_obs[11]), 32'd1);
        instrD = 8'h00;
        cycle("ret_c2");
        check_eq("ret_c2_ctl", ctl(), 32'h0);

`ifdef DECODE_SEQ_INTR_EN
        instrD = 8'h35; pcD = 8'h41; intr = 1;
        cycle("int_latch");
        check_eq("int_latch_ctl", ctl(), 32'h0);
        cycle("int_take");
        check_eq("int_take_ctl", ctl(), 32'h0);
        intr = 0;
        cycle("int_push");
        check_eq("int_push_pu", 32'(last_obs[10]), 32'd1);
        check_eq("int_push_ret_pc", 32'(last_obs[7:0]), 32'h41);
        cycle("int_vec");
        check_eq("int_vec_mux", 32'(last_obs[18:16]), 32'd2);
        check_eq("int_vec_ack", 32'(last_obs[8]), 32'd1);
        intr = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("int_masked");
            check_eq("int_masked_ctl", ctl(), 32'h0);
        end
        instrD = 8'hB8;
        cycle("rti_c0");
        check_eq("rti_c0_pop", 32'(last_obs[9]), 32'd1);
        instrD = 8'h35;
        cycle("rti_c1");
        check_eq("rti_c1_mux", 32'(last_obs[18:16]), 32'd3);
        cycle("int2_latch");
        cycle("int2_take");
        intr = 0;
        cycle("int2_push");
        check_eq("int2_push_pu", 32'(last_obs[10]), 32'd1);
        cycle("int2_vec");
        check_eq("int2_vec_ack", 32'(last_obs[8]), 32'd1);
        instrD = 8'hB8;
        cycle("rti2_c0");
        instrD = 8'h00;
        cycle("rti2_c1");
`endif

        instrD = 8'hC1; hz_stall = 1;
        cycle("hz");
        check_eq("hz_sf_sd_ir", 32'({last_obs[13], last_obs[12], last_obs[14]}), 32'b110);
        hz_stall = 0;
        cycle("two_word");
        check_eq("two_word_ir_fd", 32'({last_obs[14], last_obs[11]}), 32'b11);

        instrD = 8'hBC;
        cycle("stack_nop");
        check_eq("stack_nop_ctl", ctl(), 32'h0);

        instrD = 8'hB0; pcD = 8'hFF;
        cycle("call_wrap");
        check_eq("call_wrap_ret_pc", 32'(last_obs[7:0]), 32'h00);
        check_eq("call_wrap_push_mux", 32'({last_obs[10], last_obs[18:16]}), 32'b1001);

        instrD = 8'hB4; pcD = 8'h10;
        cycle("ret_abort_c0");
        reset = 1;
        cycle("ret_abort_rst");
        check_eq("ret_abort_rst_ctl", ctl(), 32'h0);
        reset = 0; instrD = 8'h00;
        cycle("ret_abort_nop");
        check_eq("ret_abort_nop_ctl", ctl(), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            instrD   = {op_tbl[$urandom_range(0, 9)], 4'($urandom)};
            pcD      = 8'($urandom);
            flag_z   = 1'($urandom);
            flag_n   = 1'($urandom);
            flag_c   = 1'($urandom);
            or_out   = 1'($urandom);
            hz_stall = ($urandom_range(0, 5) == 0);
            intr     = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 96) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
